// File: rtl/riscky_pkg.sv
// Shared types and constants for the riscky core front end.
package riscky_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {pc, instr} entries between imem responses and IF/ID.
module fetch_queue
  import riscky_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         clear,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: PC, imem requests, response queue and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module fetch
  import riscky_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic [ILEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0]     perf_fetched,
  output logic [63:0]     perf_bubbles
`endif
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  fetch_state_t    state;
  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   q_count;
  logic            q_full;
  logic            q_empty;
  fetch_entry_t    q_head;
  fetch_entry_t    rsp_entry;

  logic [SW-1:0]   credit_used;
  logic [XLEN-1:0] redirect_pc;
  logic [CW-1:0]   out_after_rsp;
  logic            hs;
  logic            rsp_seen;
  logic            rsp_take;
  logic            stage_adv;
  logic            bypass;
  logic            q_push;
  logic            q_pop;
  logic            load_nop;
  logic            take_instr;

  assign credit_used    = SW'(outstanding) + SW'(q_count);
  assign imem_req_valid = (state == S_RUN) && !pc_src_e && (credit_used < SW'(QDEPTH));
  assign imem_req_addr  = pc_f;
  assign hs             = imem_req_valid && imem_req_ready;
  assign redirect_pc    = pc_target_e & ~XLEN'(3);

  // Responses landing in S_IDLE belong to a pre-reset stream and are ignored.
  assign rsp_seen      = imem_rsp_valid && (state != S_IDLE);
  assign rsp_take      = imem_rsp_valid && (state == S_RUN) && !pc_src_e;
  assign out_after_rsp = outstanding - CW'(rsp_seen);
  assign rsp_entry     = '{pc: rsp_pc, instr: imem_rsp_data};

  // An empty queue lets a response go straight into IF/ID for 1-cycle latency.
  assign stage_adv  = !pc_src_e && !flush_d && !stall_d;
  assign bypass     = rsp_take && q_empty && stage_adv;
  assign q_push     = rsp_take && !bypass;
  assign q_pop      = stage_adv && !q_empty;
  assign take_instr = bypass || q_pop;
  assign load_nop   = pc_src_e || flush_d || (stage_adv && q_empty && !bypass);

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (rsp_entry),
    .pop       (q_pop),
    .clear     (pc_src_e),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // PC / credit / drain state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc_f        <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_RUN;
        S_RUN: begin
          if (pc_src_e) begin
            pc_f        <= redirect_pc;
            rsp_pc      <= redirect_pc;
            outstanding <= out_after_rsp;
            drop_cnt    <= out_after_rsp;
            if (out_after_rsp != '0) state <= S_DRAIN;
          end else begin
            if (hs)       pc_f   <= pc_f + XLEN'(4);
            if (rsp_take) rsp_pc <= rsp_pc + XLEN'(4);
            outstanding <= outstanding + CW'(hs) - CW'(rsp_seen);
          end
        end
        S_DRAIN: begin
          if (pc_src_e) begin
            pc_f   <= redirect_pc;
            rsp_pc <= redirect_pc;
          end
          if (rsp_seen) begin
            outstanding <= out_after_rsp;
            drop_cnt    <= drop_cnt - CW'(1);
            if (drop_cnt == CW'(1)) state <= S_RUN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (rst || load_nop) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
    end else if (take_instr) begin
      instr_d    <= bypass ? rsp_entry.instr : q_head.instr;
      pc_d       <= bypass ? rsp_entry.pc : q_head.pc;
      pc_plus4_d <= (bypass ? rsp_entry.pc : q_head.pc) + XLEN'(4);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (take_instr) perf_fetched <= perf_fetched + 64'd1;
      if (load_nop)   perf_bubbles <= perf_bubbles + 64'd1;
    end
  end
`endif

  assert property (@(posedge clk) disable iff (rst) !(q_push && q_full && !q_pop));

endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for the fetch stage with a fixed-latency imem model.
module tb_fetch;
  import riscky_pkg::*;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        stall_d;
  logic        flush_d;
  logic        pc_src_e;
  logic [63:0] pc_target_e;
  logic [31:0] instr_d;
  logic [63:0] pc_d;
  logic [63:0] pc_plus4_d;
`ifdef FETCH_PERF_CNT_EN
  logic [63:0] perf_fetched;
  logic [63:0] perf_bubbles;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_pc;
  int lat = 1;

  fetch #(.RESET_PC(64'h0), .QDEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .pc_src_e       (pc_src_e),
    .pc_target_e    (pc_target_e),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pc_plus4_d     (pc_plus4_d)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] img(input logic [63:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  // Memory model: in-order, fixed latency 'lat', one response per cycle.
  typedef struct {
    longint unsigned due;
    logic [63:0]     addr;
  } pend_t;
  pend_t pend[$];
  longint unsigned cyc = 0;
  int inflight = 0;

  assign imem_req_ready = 1'b1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    inflight <= inflight + int'(imem_req_valid && imem_req_ready) - int'(imem_rsp_valid);
    if (imem_req_valid && imem_req_ready)
      pend.push_back('{due: cyc + longint'(lat) - 1, addr: imem_req_addr});
    imem_rsp_valid <= 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid <= 1'b1;
      imem_rsp_data  <= img(pend[0].addr);
      void'(pend.pop_front());
    end
  end

  task automatic test_reset();
    rst = 1'b1; stall_d = 1'b0; flush_d = 1'b0; pc_src_e = 1'b0; pc_target_e = '0; lat = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (instr_d !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", instr_d, NOP); end
    checks++;
    if (pc_d !== 64'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc_d); end
    checks++;
    if (pc_plus4_d !== 64'h0) begin errors++; $display("FAIL reset_pc4 got %h want 0", pc_plus4_d); end
    checks++;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", imem_req_valid); end
  endtask

  task automatic test_stream();
    int n;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
      errors++; $display("FAIL first_req got valid=%b addr=%h want valid=1 addr=0", imem_req_valid, imem_req_addr);
    end
    @(negedge clk);
    checks++;
    if (instr_d !== NOP) begin errors++; $display("FAIL early_instr got %h want %h", instr_d, NOP); end
    @(negedge clk);
    checks++;
    if (instr_d !== img(64'h0) || pc_d !== 64'h0 || pc_plus4_d !== 64'h4) begin
      errors++; $display("FAIL first_instr got %h/%h/%h want %h/0/4", instr_d, pc_d, pc_plus4_d, img(64'h0));
    end
    exp_pc = 64'h4;
    n = 0;
    for (int i = 0; i < 40 && n < 7; i++) begin
      @(negedge clk);
      if (instr_d !== NOP) begin
        checks++;
        if (instr_d !== img(exp_pc) || pc_d !== exp_pc || pc_plus4_d !== exp_pc + 64'd4) begin
          errors++; $display("FAIL stream got %h/%h/%h want %h/%h/%h", instr_d, pc_d, pc_plus4_d, img(exp_pc), exp_pc, exp_pc + 64'd4);
        end
        exp_pc += 64'd4; n++;
      end
    end
    checks++;
    if (n != 7) begin errors++; $display("FAIL stream_count got %0d want 7", n); end
  endtask

  task automatic test_stall();
    logic [31:0] held_i;
    logic [63:0] held_pc;
    int n;
    held_i = instr_d; held_pc = pc_d;
    stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (instr_d !== held_i || pc_d !== held_pc) begin
        errors++; $display("FAIL stall_hold got %h/%h want %h/%h", instr_d, pc_d, held_i, held_pc);
      end
      checks++;
      if (inflight > 2) begin errors++; $display("FAIL stall_inflight got %0d want <=2", inflight); end
    end
    stall_d = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && n < 6; i++) begin
      @(negedge clk);
      if (instr_d !== NOP) begin
        checks++;
        if (instr_d !== img(exp_pc) || pc_d !== exp_pc || pc_plus4_d !== exp_pc + 64'd4) begin
          errors++; $display("FAIL after_stall got %h/%h want %h/%h", instr_d, pc_d, img(exp_pc), exp_pc);
        end
        exp_pc += 64'd4; n++;
      end
    end
    checks++;
    if (n != 6) begin errors++; $display("FAIL after_stall_count got %0d want 6", n); end
  endtask

  task automatic test_redirect();
    bit got;
    int n;
    lat = 3;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (inflight >= 2) got = 1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL redirect_setup got inflight=%0d want 2", inflight); end
    pc_src_e = 1'b1; pc_target_e = 64'h103;
    @(negedge clk);
    pc_src_e = 1'b0;
    checks++;
    if (instr_d !== NOP || pc_d !== 64'h0 || pc_plus4_d !== 64'h0) begin
      errors++; $display("FAIL redirect_nop got %h/%h/%h want %h/0/0", instr_d, pc_d, pc_plus4_d, NOP);
    end
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (instr_d !== NOP) begin errors++; $display("FAIL drain_stale got %h want %h", instr_d, NOP); end
      if (imem_req_valid && imem_req_ready) begin
        got = 1;
        checks++;
        if (imem_req_addr !== 64'h100) begin errors++; $display("FAIL redirect_addr got %h want 100", imem_req_addr); end
      end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL redirect_timeout got no request want addr 100"); end
    exp_pc = 64'h100;
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (instr_d !== NOP) begin
        checks++;
        if (instr_d !== img(exp_pc) || pc_d !== exp_pc || pc_plus4_d !== exp_pc + 64'd4) begin
          errors++; $display("FAIL redirect_stream got %h/%h want %h/%h", instr_d, pc_d, img(exp_pc), exp_pc);
        end
        exp_pc += 64'd4; n++;
      end
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL redirect_count got %0d want 3", n); end
    // Redirect to the top of the address space: pc_plus4_d must wrap to 0.
    pc_src_e = 1'b1; pc_target_e = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    pc_src_e = 1'b0;
    exp_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    n = 0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      @(negedge clk);
      if (instr_d !== NOP) begin
        checks++;
        if (instr_d !== img(exp_pc) || pc_d !== exp_pc || pc_plus4_d !== exp_pc + 64'd4) begin
          errors++; $display("FAIL wrap got %h/%h/%h want %h/%h/%h", instr_d, pc_d, pc_plus4_d, img(exp_pc), exp_pc, exp_pc + 64'd4);
        end
        exp_pc += 64'd4; n++;
      end
    end
    checks++;
    if (n != 2) begin errors++; $display("FAIL wrap_count got %0d want 2", n); end
  endtask

  task automatic test_flush_stall();
    int n;
    lat = 1;
    flush_d = 1'b1; stall_d = 1'b1;
    @(negedge clk);
    flush_d = 1'b0; stall_d = 1'b0;
    checks++;
    if (instr_d !== NOP || pc_d !== 64'h0 || pc_plus4_d !== 64'h0) begin
      errors++; $display("FAIL flush_nop got %h/%h/%h want %h/0/0", instr_d, pc_d, pc_plus4_d, NOP);
    end
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (instr_d !== NOP) begin
        checks++;
        if (instr_d !== img(exp_pc) || pc_d !== exp_pc) begin
          errors++; $display("FAIL after_flush got %h/%h want %h/%h", instr_d, pc_d, img(exp_pc), exp_pc);
        end
        exp_pc += 64'd4; n++;
      end
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL after_flush_count got %0d want 3", n); end
  endtask

  task automatic test_reset_midflight();
    bit got;
    int n;
    lat = 3;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (inflight >= 1) got = 1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL midflight_setup got inflight=%0d want >=1", inflight); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (instr_d !== NOP || pc_d !== 64'h0 || pc_plus4_d !== 64'h0 || imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL midflight_reset got %h/%h/%h/%b want %h/0/0/0", instr_d, pc_d, pc_plus4_d, imem_req_valid, NOP);
    end
    lat = 1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
      errors++; $display("FAIL midflight_first got valid=%b addr=%h want 1/0", imem_req_valid, imem_req_addr);
    end
    exp_pc = 64'h0;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (instr_d !== NOP) begin
        checks++;
        if (instr_d !== img(exp_pc) || pc_d !== exp_pc || pc_plus4_d !== exp_pc + 64'd4) begin
          errors++; $display("FAIL midflight_stream got %h/%h want %h/%h", instr_d, pc_d, img(exp_pc), exp_pc);
        end
        exp_pc += 64'd4; n++;
      end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL midflight_count got %0d want 4", n); end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    int n;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (perf_fetched !== 64'd0 || perf_bubbles !== 64'd0) begin
      errors++; $display("FAIL perf_reset got %0d/%0d want 0/0", perf_fetched, perf_bubbles);
    end
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 60 && n < 10; i++) begin
      @(negedge clk);
      flush_d = 1'b0;
      if (instr_d !== NOP) begin
        n++;
        if (n == 5) flush_d = 1'b1;
      end
    end
    flush_d = 1'b0;
    checks++;
    if (perf_fetched !== 64'd10) begin errors++; $display("FAIL perf_fetched got %0d want 10", perf_fetched); end
    checks++;
    if (perf_bubbles < 64'd1) begin errors++; $display("FAIL perf_bubbles got %0d want >=1", perf_bubbles); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_flush_stall();
    test_reset_midflight();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
